// File: rtl/uart_bit_receiver.sv
// UART receive deserialiser: oversampled start qualification, centre-sampled data and stop bits,
// one-cycle char_received strobe and a sticky framing_error until the next stop-bit evaluation.
module uart_bit_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_in,
    input  logic                 sample_enable,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 char_received,
    output logic [3:0]           bit_count,
    output logic                 framing_error,
    output logic                 busy
);
    localparam int                SCNT_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [SCNT_W-1:0] SCNT_MID  = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0]        BITS_LAST = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t               state, state_nxt;
    logic [SCNT_W-1:0]    scnt, scnt_nxt;
    logic [3:0]           bit_count_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic [DATA_BITS-1:0] data_out_nxt;
    logic                 char_received_nxt;
    logic                 framing_error_nxt;
    logic                 armed, armed_nxt;
    logic                 rx_p0, rx_s;
    logic                 vld_p0, vld_p1;

    // Stage p0/p1: two-flop synchroniser; vld marks when rx_s carries a real line sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_p0  <= 1'b1;
            rx_s   <= 1'b1;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            rx_p0  <= serial_in;
            rx_s   <= rx_p0;
            vld_p0 <= 1'b1;
            vld_p1 <= vld_p0;
        end
    end

    // Stage p2: receiver state, counters and outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            scnt          <= '0;
            bit_count     <= '0;
            shift         <= '1;
            data_out      <= '0;
            char_received <= 1'b0;
            framing_error <= 1'b0;
            armed         <= 1'b0;
        end else begin
            state         <= state_nxt;
            scnt          <= scnt_nxt;
            bit_count     <= bit_count_nxt;
            shift         <= shift_nxt;
            data_out      <= data_out_nxt;
            char_received <= char_received_nxt;
            framing_error <= framing_error_nxt;
            armed         <= armed_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        scnt_nxt          = scnt;
        bit_count_nxt     = bit_count;
        shift_nxt         = shift;
        data_out_nxt      = data_out;
        char_received_nxt = 1'b0;
        framing_error_nxt = framing_error;
        armed_nxt         = armed;
        if (sample_enable) begin
            unique case (state)
                IDLE: begin
                    // A reset mid-frame must not treat the remaining low bits as a new start edge
                    if (rx_s && vld_p1) begin
                        armed_nxt = 1'b1;
                    end
                    if (!rx_s && armed) begin
                        state_nxt     = START;
                        scnt_nxt      = '0;
                        bit_count_nxt = '0;
                    end
                end
                START: begin
                    if (scnt == SCNT_MID) begin
                        scnt_nxt  = '0;
                        state_nxt = rx_s ? IDLE : DATA;
                    end else begin
                        scnt_nxt = scnt + 1'b1;
                    end
                end
                DATA: begin
                    if (scnt == SCNT_LAST) begin
                        scnt_nxt      = '0;
                        shift_nxt     = {rx_s, shift[DATA_BITS-1:1]};
                        bit_count_nxt = bit_count + 4'd1;
                        if (bit_count == BITS_LAST) begin
                            state_nxt = STOP;
                        end
                    end else begin
                        scnt_nxt = scnt + 1'b1;
                    end
                end
                STOP: begin
                    if (scnt == SCNT_LAST) begin
                        scnt_nxt = '0;
                        if (rx_s) begin
                            data_out_nxt      = shift;
                            char_received_nxt = 1'b1;
                            framing_error_nxt = 1'b0;
                            state_nxt         = IDLE;
                        end else begin
                            framing_error_nxt = 1'b1;
                            state_nxt         = BREAK;
                        end
                    end else begin
                        scnt_nxt = scnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/uart_bit_receiver.md
Name: uart_bit_receiver

Overview:
Receive-side counterpart of the serial transmit bit counter: deserialises one 8N1 UART character from the inter-board serial line into a parallel byte. Runs from the system clock and advances only on a 16x-baud sample_enable tick supplied by the shared baud generator. Signals each completed character with a one-cycle char_received pulse to the game-state logic. Also flags stop-bit violations as framing errors.

Parameters:
DATA_BITS, 8, number of data bits per character, sent LSB first (legal 5..15)
OVERSAMPLE, 16, sample_enable ticks per bit period (even, >= 4)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
serial_in  input  1  raw asynchronous serial line; idle high
sample_enable  input  1  one-clk tick at OVERSAMPLE x baud; logic advances only when high
data_out  output  DATA_BITS  last correctly framed character; held until the next good frame
char_received  output  1  one-clk pulse when data_out has just been updated
bit_count  output  4  number of data bits shifted in so far in the current frame (0..DATA_BITS)
framing_error  output  1  high after a frame whose stop bit sampled low
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset is asynchronous and active-high. Reset values: state=IDLE, data_out=0, char_received=0, bit_count=0, framing_error=0, busy=0. Both synchroniser flops and the shift register reset to 1s; the sample counter resets to 0.
- serial_in passes through a 2-flop synchroniser (rx_s); rx_s lags the pin by 2 clk. All decisions use rx_s.
- Sample counter (scnt, width clog2(OVERSAMPLE)) increments only on sample_enable. With sample_enable low, no state, counter or output changes, except that char_received drops after its single cycle.
- FSM states:
  - IDLE: on a tick with rx_s=0, go to START with scnt=0 and bit_count=0.
  - START: on a tick, when scnt==OVERSAMPLE/2-1 (mid start bit), test rx_s.
    - rx_s=0: go to DATA with scnt=0.
    - rx_s=1: glitch; return to IDLE with no outputs changed.
    - Otherwise scnt++.
  - DATA: on a tick, when scnt==OVERSAMPLE-1 (mid data bit):
    - shift = {rx_s, shift[DATA_BITS-1:1]}, bit_count++, scnt=0.
    - When bit_count reaches DATA_BITS, go to STOP.
  - STOP: on a tick, when scnt==OVERSAMPLE-1 (mid stop bit):
    - rx_s=1: data_out<=shift, char_received=1 on the next clk for exactly one clk, framing_error<=0, go to IDLE.
    - rx_s=0: framing_error<=1, data_out unchanged, no pulse, go to BREAK.
  - BREAK: wait for a tick with rx_s=1, then go to IDLE. This stops a held-low line from spawning false frames.
- framing_error is held until the next STOP evaluation or reset.
- bit_count stays at DATA_BITS through STOP and returns to 0 on the next START entry.
- busy is a combinational decode of state.
- Back-to-back frames: IDLE is entered at mid stop bit, so a start edge arriving immediately after the stop bit is detected. No minimum idle gap is required.
- Reset mid-frame: the partial frame is discarded, no pulse is produced, and the next frame needs a fresh low level from IDLE.
- Latency: for 8N1 with OVERSAMPLE=16 and sample_enable tied high, char_received occurs 2 (sync) + 8 + 16*8 + 16 + 1 = 155 clk after the start-bit falling edge on serial_in.

Test Plan:
- sample_enable=1 every clk, send 0xA5 LSB first (16 clk per bit, stop=1) -> bit_count steps 1..8; data_out=0xA5; char_received high exactly 1 clk, 155 clk after the start edge; framing_error=0; busy drops with the pulse.
- Low glitch on serial_in lasting 4 clk while idle -> START then back to IDLE; no pulse; bit_count=0; data_out unchanged.
- Frame 0x3C with stop bit driven 0 after a prior good 0x11 -> framing_error=1, data_out stays 0x11, no pulse. Line held low 64 clk -> stays in BREAK with no new frame. Line high, then good 0x3C -> framing_error=0, data_out=0x3C.
- Back-to-back 0x00 then 0xFF with zero idle gap -> two pulses 160 clk apart; data_out=0x00 then 0xFF.
- sample_enable one clk in four, send 0x5A at 64 clk/bit -> data_out=0x5A. Gating sample_enable low for 100 clk mid-frame freezes bit_count and busy.
- Assert reset for 1 clk at bit_count=4 of frame 0xC3 -> all outputs return to reset values immediately; the remainder of the frame produces no pulse; the next full frame 0x81 is received correctly.
